// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-wide SPI master and its CSR mapping.
// Imported by spi_clk_div and spi_master.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SCLK_HI,
      ST_SCLK_LO,
      ST_HOLD
   } spi_state_t;

   localparam logic [31:0] SPI_CSR_CMD_ADDR  = 32'h800;
   localparam logic [31:0] SPI_CSR_CTRL_ADDR = 32'h801;
   localparam int          SPI_CSR_BUSY_BIT  = 0;
   localparam int          SPI_DIV_W         = 8;

endpackage

// File: rtl/spi_clk_div.sv
// Loadable half-period down-counter. tick_o is high for the last cycle of each
// DIV-cycle phase while enabled; the caller reloads on every phase change.
module spi_clk_div
   import spi_pkg::*;
#(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic load_i,
   output logic tick_o
);

   localparam logic [SPI_DIV_W-1:0] RELOAD = SPI_DIV_W'(DIV - 1);

   logic [SPI_DIV_W-1:0] cnt_q;
   logic [SPI_DIV_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = RELOAD;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 0, MSB first; busy spans exactly 18*CLK_DIV cycles.
// Optional SPI_MISO_SYNC_EN adds a two-flop MISO synchronizer (needs CLK_DIV >= 3).
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_trigger,
   input  logic [7:0] spi_command,
   output logic [7:0] spi_response,
   output logic       spi_busy,
   output logic       spi_done,
   output logic       spi_sclk,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       spi_cs_n
);

   spi_state_t state_q, state_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] resp_q, resp_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       bits_done_q, bits_done_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       cs_n_q, cs_n_d;
   logic       sclk_q, sclk_d;
   logic       accept;
   logic       tick;
   logic       miso_s;

`ifdef SPI_MISO_SYNC_EN
   logic miso_meta_q;
   logic miso_sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         miso_meta_q <= 1'b0;
         miso_sync_q <= 1'b0;
      end else begin
         miso_meta_q <= spi_miso;
         miso_sync_q <= miso_meta_q;
      end
   end

   assign miso_s = miso_sync_q;
`else
   assign miso_s = spi_miso;
`endif

   spi_clk_div #(
      .DIV (CLK_DIV)
   ) u_clk_div (
      .clk    (clk),
      .rst    (rst),
      .en_i   (state_q != ST_IDLE),
      .load_i (accept || tick),
      .tick_o (tick)
   );

   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      resp_d      = resp_q;
      bit_cnt_d   = bit_cnt_q;
      bits_done_d = bits_done_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      cs_n_d      = cs_n_q;
      sclk_d      = sclk_q;
      accept      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (spi_trigger) begin
               accept      = 1'b1;
               tx_d        = spi_command;
               rx_d        = 8'h00;
               bit_cnt_d   = 3'd0;
               bits_done_d = 1'b0;
               busy_d      = 1'b1;
               cs_n_d      = 1'b0;
               sclk_d      = 1'b0;
               state_d     = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tick) begin
               sclk_d  = 1'b1;
               rx_d    = {rx_q[6:0], miso_s};
               state_d = ST_SCLK_HI;
            end
         end
         ST_SCLK_HI: begin
            // Zero shifts in from the right so MOSI idles low after bit 0.
            if (tick) begin
               sclk_d    = 1'b0;
               tx_d      = {tx_q[6:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  bits_done_d = 1'b1;
               end
               state_d = ST_SCLK_LO;
            end
         end
         ST_SCLK_LO: begin
            if (tick) begin
               if (bits_done_q) begin
                  state_d = ST_HOLD;
               end else begin
                  sclk_d  = 1'b1;
                  rx_d    = {rx_q[6:0], miso_s};
                  state_d = ST_SCLK_HI;
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               cs_n_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               resp_d  = rx_q;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tx_q        <= 8'h00;
         rx_q        <= 8'h00;
         resp_q      <= 8'h00;
         bit_cnt_q   <= 3'd0;
         bits_done_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         resp_q      <= resp_d;
         bit_cnt_q   <= bit_cnt_d;
         bits_done_q <= bits_done_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cs_n_q      <= cs_n_d;
         sclk_q      <= sclk_d;
      end
   end

   // MOSI is the shift register MSB, so it is registered with no extra flop.
   assign spi_mosi     = tx_q[7];
   assign spi_sclk     = sclk_q;
   assign spi_cs_n     = cs_n_q;
   assign spi_busy     = busy_q;
   assign spi_done     = done_q;
   assign spi_response = resp_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: two instances (fast divider and CLK_DIV=5)
// driven by table vectors, hand sequences and random bytes against a slave model.
module tb_spi_master;

`ifdef SPI_MISO_SYNC_EN
   localparam int DIV_A = 3;
`else
   localparam int DIV_A = 2;
`endif
   localparam int DIV_B = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      trig = 2'b00;
   logic [1:0][7:0] cmd = '0;
   logic [1:0][7:0] resp;
   logic [1:0]      busy;
   logic [1:0]      done;
   logic [1:0]      sclk;
   logic [1:0]      mosi;
   logic [1:0]      miso = 2'b00;
   logic [1:0]      cs_n;

   always #5 clk = ~clk;

   spi_master #(.CLK_DIV(DIV_A)) u_dut_a (
      .clk          (clk),
      .rst          (rst),
      .spi_trigger  (trig[0]),
      .spi_command  (cmd[0]),
      .spi_response (resp[0]),
      .spi_busy     (busy[0]),
      .spi_done     (done[0]),
      .spi_sclk     (sclk[0]),
      .spi_mosi     (mosi[0]),
      .spi_miso     (miso[0]),
      .spi_cs_n     (cs_n[0])
   );

   spi_master #(.CLK_DIV(DIV_B)) u_dut_b (
      .clk          (clk),
      .rst          (rst),
      .spi_trigger  (trig[1]),
      .spi_command  (cmd[1]),
      .spi_response (resp[1]),
      .spi_busy     (busy[1]),
      .spi_done     (done[1]),
      .spi_sclk     (sclk[1]),
      .spi_mosi     (mosi[1]),
      .spi_miso     (miso[1]),
      .spi_cs_n     (cs_n[1])
   );

   // Mode-0 slave: presents MSB when CS falls, advances on each SCLK fall.
   logic [1:0][7:0] slave_byte = '0;
   logic [1:0][7:0] slave_sr = '0;
   logic [1:0]      prev_sclk = 2'b00;
   logic [1:0]      prev_cs = 2'b11;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (prev_cs[d] === 1'b1 && cs_n[d] === 1'b0) begin
            slave_sr[d] = slave_byte[d];
         end else if (prev_sclk[d] === 1'b1 && sclk[d] === 1'b0) begin
            slave_sr[d] = {slave_sr[d][6:0], 1'b0};
         end
         prev_sclk[d] = sclk[d];
         prev_cs[d]   = cs_n[d];
      end
      miso = {slave_sr[1][7], slave_sr[0][7]};
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int div_of(input int d);
      return (d == 0) ? DIV_A : DIV_B;
   endfunction

   // Observations of the last transfer.
   logic [7:0] r_mosi;
   logic [7:0] r_resp;
   int         r_busy, r_pulses, r_dones, r_setup;
   int         hi_min, hi_max, lo_min, lo_max;
   bit         r_timeout;

   // Caller is at a negedge; trigger is sampled at the following posedge.
   task automatic xfer(input int d, input logic [7:0] c, input logic [7:0] s,
                       input int rt1, input int rt2, input bit end_trig);
      bit prev_s;
      int run;
      slave_byte[d] = s;
      trig[d] = 1'b1;
      cmd[d]  = c;
      @(negedge clk);
      trig[d] = 1'b0;
      cmd[d]  = 8'($urandom);
      r_mosi = 8'h00; r_resp = 8'h00; r_busy = 0; r_pulses = 0; r_dones = 0;
      r_setup = 0; hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
      prev_s = 1'b0; run = 0; r_timeout = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         trig[d] = 1'b0;
         if (busy[d]) r_busy++;
         if (done[d]) begin
            r_dones++;
            r_resp = resp[d];
         end
         if (sclk[d] != prev_s) begin
            if (prev_s) begin
               if (run < hi_min) hi_min = run;
               if (run > hi_max) hi_max = run;
            end else if (r_pulses > 0) begin
               if (run < lo_min) lo_min = run;
               if (run > lo_max) lo_max = run;
            end else begin
               r_setup = run;
            end
            if (sclk[d]) begin
               r_pulses++;
               r_mosi = {r_mosi[6:0], mosi[d]};
            end
            run = 0;
         end
         run++;
         prev_s = sclk[d];
         if (!busy[d]) begin
            r_timeout = 1'b0;
            break;
         end
         if (cyc == rt1 || cyc == rt2 || (end_trig && r_busy == 18 * div_of(d))) begin
            trig[d] = 1'b1;
            cmd[d]  = 8'hFF;
         end
         @(negedge clk);
      end
      trig[d] = 1'b0;
   endtask

   task automatic check_xfer(input int d, input string tag,
                             input logic [7:0] exp_mosi, input logic [7:0] exp_resp);
      int dv;
      dv = div_of(d);
      chk({tag, " timeout"}, 32'(r_timeout), 0);
      chk({tag, " mosi_bits"}, 32'(r_mosi), 32'(exp_mosi));
      chk({tag, " sclk_pulses"}, r_pulses, 8);
      chk({tag, " busy_cycles"}, r_busy, 18 * dv);
      chk({tag, " done_pulses"}, r_dones, 1);
      chk({tag, " response_at_done"}, 32'(r_resp), 32'(exp_resp));
      chk({tag, " response_port"}, 32'(resp[d]), 32'(exp_resp));
      chk({tag, " setup_len"}, r_setup, dv);
      chk({tag, " sclk_hi_min"}, hi_min, dv);
      chk({tag, " sclk_hi_max"}, hi_max, dv);
      chk({tag, " sclk_lo_min"}, lo_min, dv);
      chk({tag, " sclk_lo_max"}, lo_max, dv);
      $display("xfer %s: dut=%0d cmd_bits=%02h resp=%02h busy=%0d pulses=%0d",
               tag, d, r_mosi, r_resp, r_busy, r_pulses);
   endtask

   task automatic check_reset_outputs(input int d, input string tag);
      chk({tag, " cs_n"}, 32'(cs_n[d]), 1);
      chk({tag, " sclk"}, 32'(sclk[d]), 0);
      chk({tag, " mosi"}, 32'(mosi[d]), 0);
      chk({tag, " busy"}, 32'(busy[d]), 0);
      chk({tag, " done"}, 32'(done[d]), 0);
      chk({tag, " response"}, 32'(resp[d]), 0);
   endtask

   typedef struct {
      logic [7:0] cmd;
      logic [7:0] slave;
      int         rt1;
      int         rt2;
      bit         end_trig;
      logic [7:0] exp_mosi;
      logic [7:0] exp_resp;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] c, s;
      vecs[0] = '{8'hA5, 8'h3C, -1, -1, 1'b0, 8'hA5, 8'h3C};   // basic
      vecs[1] = '{8'h11, 8'h96,  5, 20, 1'b0, 8'h11, 8'h96};   // busy lockout
      vecs[2] = '{8'h01, 8'h55, -1, -1, 1'b1, 8'h01, 8'h55};   // back-to-back first
      vecs[3] = '{8'h80, 8'hAA, -1, -1, 1'b0, 8'h80, 8'hAA};   // back-to-back second
      vecs[4] = '{8'h00, 8'hFF, -1, -1, 1'b0, 8'h00, 8'hFF};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs(0, "reset_a");
      check_reset_outputs(1, "reset_b");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         xfer(0, vecs[i].cmd, vecs[i].slave, vecs[i].rt1, vecs[i].rt2, vecs[i].end_trig);
         check_xfer(0, $sformatf("vec%0d", i), vecs[i].exp_mosi, vecs[i].exp_resp);
         if (vecs[i].end_trig) begin
            // Trigger at the busy-fall edge must be ignored.
            chk($sformatf("vec%0d ignore_trig_at_fall busy", i), 32'(busy[0]), 0);
            chk($sformatf("vec%0d gap cs_n", i), 32'(cs_n[0]), 1);
         end else begin
            @(negedge clk);
            chk($sformatf("vec%0d done_one_cycle", i), 32'(done[0]), 0);
            chk($sformatf("vec%0d idle_busy", i), 32'(busy[0]), 0);
            chk($sformatf("vec%0d resp_hold", i), 32'(resp[0]), 32'(vecs[i].exp_resp));
         end
      end

      // Abort mid-transfer with reset, then a clean transfer.
      slave_byte[0] = 8'h77;
      trig[0] = 1'b1;
      cmd[0]  = 8'hC3;
      @(negedge clk);
      trig[0] = 1'b0;
      repeat (9) @(negedge clk);
      chk("abort in_progress busy", 32'(busy[0]), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs(0, "abort");
      @(negedge clk);
      chk("abort stays_idle busy", 32'(busy[0]), 0);
      $display("abort: outputs at reset values after rst");
      xfer(0, 8'h5A, 8'hE1, -1, -1, 1'b0);
      check_xfer(0, "after_abort", 8'h5A, 8'hE1);
      @(negedge clk);

      // Divider scaling on the CLK_DIV=5 instance.
      xfer(1, 8'hFF, 8'hFF, -1, -1, 1'b0);
      check_xfer(1, "div5_ff", 8'hFF, 8'hFF);
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         c = 8'($urandom);
         s = 8'($urandom);
         xfer(0, c, s, -1, -1, 1'b0);
         check_xfer(0, $sformatf("rand_a%0d", i), c, s);
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         c = 8'($urandom);
         s = 8'($urandom);
         xfer(1, c, s, -1, -1, 1'b0);
         check_xfer(1, $sformatf("rand_b%0d", i), c, s);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
